// File: rtl/fact_pkg.sv
// Shared types and constants for the memory-mapped factorial accelerator.
package fact_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MULT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Register offsets, indexed by a[3:2]
  localparam logic [1:0] OFF_N    = 2'd0;
  localparam logic [1:0] OFF_GO   = 2'd1;
  localparam logic [1:0] OFF_STAT = 2'd2;
  localparam logic [1:0] OFF_RES  = 2'd3;

  localparam int unsigned MAX_N = 12;

  localparam int STAT_DONE = 0;
  localparam int STAT_ERR  = 1;
  localparam int STAT_BUSY = 2;

endpackage

// File: rtl/fact_dp.sv
// Iterative multiply datapath: accumulator and down-counter for n!.
module fact_dp #(
  parameter int WIDTH  = 32,
  parameter int N_BITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld,
  input  logic              mul,
  input  logic [N_BITS-1:0] n,
  output logic [WIDTH-1:0]  acc,
  output logic              cnt_le1
);

  logic [WIDTH-1:0]  acc_reg;
  logic [N_BITS-1:0] cnt_reg;

  assign cnt_le1 = (cnt_reg <= N_BITS'(1));
  assign acc     = acc_reg;

  // Once the counter reaches 1 (or starts at 0) the accumulator is frozen
  // so the controller can capture it on its exit edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (ld) begin
      acc_reg <= WIDTH'(1);
      cnt_reg <= n;
    end else if (mul && !cnt_le1) begin
      acc_reg <= acc_reg * WIDTH'(cnt_reg);
      cnt_reg <= cnt_reg - N_BITS'(1);
    end
  end

endmodule

// File: rtl/fact_accel.sv
// Factorial accelerator on the data-memory bus: address decode, N/GO/STATUS/RESULT
// registers, sequencing FSM and zero-latency read mux.
module fact_accel
  import fact_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               N_BITS    = 4,
  parameter logic [WIDTH-1:0] BASE_ADDR = 32'h0000_0800
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] wd,
  output logic             sel,
  output logic [WIDTH-1:0] rd,
  output logic             busy
);

  state_t            state_reg;
  logic [N_BITS-1:0] n_reg;
  logic              done_reg;
  logic              err_reg;
  logic              busy_reg;
  logic [WIDTH-1:0]  res_reg;

  logic              wr_en;
  logic              go_req;
  logic              running;
  logic [31:0]       n_ext;
  logic [WIDTH-1:0]  acc;
  logic              cnt_le1;
  logic              ld;
  logic              mul;
  logic              unused_bits;

  assign sel         = (a[WIDTH-1:4] == BASE_ADDR[WIDTH-1:4]);
  assign wr_en       = we && sel;
  assign go_req      = wr_en && (a[3:2] == OFF_GO) && wd[0];
  assign running     = (state_reg == LOAD) || (state_reg == MULT);
  assign n_ext       = 32'(n_reg);
  assign ld          = (state_reg == LOAD);
  assign mul         = (state_reg == MULT);
  assign busy        = busy_reg;
  assign unused_bits = &{1'b0, wd[WIDTH-1:N_BITS], a[1:0]};

  fact_dp #(
    .WIDTH (WIDTH),
    .N_BITS(N_BITS)
  ) u_dp (
    .clk    (clk),
    .reset  (reset),
    .ld     (ld),
    .mul    (mul),
    .n      (n_reg),
    .acc    (acc),
    .cnt_le1(cnt_le1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      n_reg     <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      res_reg   <= '0;
    end else begin
      // N is frozen while a run is in flight so the datapath sees a stable operand.
      if (wr_en && (a[3:2] == OFF_N) && !running)
        n_reg <= wd[N_BITS-1:0];

      case (state_reg)
        IDLE, DONE: begin
          if (go_req) begin
            if (n_ext > MAX_N) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
              err_reg   <= 1'b1;
              res_reg   <= '0;
            end else begin
              state_reg <= LOAD;
              done_reg  <= 1'b0;
              err_reg   <= 1'b0;
              busy_reg  <= 1'b1;
            end
          end
        end
        LOAD: state_reg <= MULT;
        MULT: begin
          if (cnt_le1) begin
            state_reg <= DONE;
            res_reg   <= acc;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd = '0;
    if (sel) begin
      case (a[3:2])
        OFF_N:    rd = WIDTH'(n_reg);
        OFF_STAT: begin
          rd[STAT_DONE] = done_reg;
          rd[STAT_ERR]  = err_reg;
          rd[STAT_BUSY] = busy_reg;
        end
        OFF_RES:  rd = res_reg;
        default:  rd = '0;
      endcase
    end
  end

endmodule
